// File: rtl/decim_seq_pkg.sv
// Shared types and constants for the decimation-chain sequencer.
package decim_seq_pkg;

    // Sequencer states: idle, chain flush, start-up transient discard, forwarding.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SETTLE,
        ST_RUN
    } seq_state_t;

    // Width of the dropped-sample counter.
    localparam int OVR_W = 16;

    // Defaults also exposed through the CSR map.
    localparam int DEF_FLUSH_CYCLES   = 64;
    localparam int DEF_SETTLE_SAMPLES = 96;

endpackage

// File: rtl/decim_hold_reg.sv
// One-entry valid/ready output register with overrun detection and a
// saturating count of samples dropped to back-pressure.
module decim_hold_reg
    import decim_seq_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             flush,
    input  logic             ovr_clear,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
    output logic [OVR_W-1:0] overrun_cnt
);

    logic accept;
    logic drop;

    // A new sample fits if the slot is empty or is being emptied this cycle.
    assign accept = in_valid && (!m_valid || m_ready);
    assign drop   = in_valid && m_valid && !m_ready;

    // Hold register: load on accept, clear on handshake or flush.
    // NOTE: state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_valid <= 1'b0;
            // NOTE: the data register is reset too, since m_data is a visible output with a defined reset value.
            m_data  <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= in_data;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Dropped-sample counter: cleared on a new capture, saturates at all ones.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            overrun_cnt <= '0;
        end else if (ovr_clear) begin
            overrun_cnt <= '0;
        end else if (drop && (overrun_cnt != '1)) begin
            overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
    end

endmodule

// File: rtl/decim_chain_seq.sv
// Sequencer and output stage for the CIC / FIR / half-band decimation chain:
// flushes the chain, discards its start-up transient, then forwards a burst.
module decim_chain_seq
    import decim_seq_pkg::*;
#(
    parameter int DW             = 16,
    parameter int FLUSH_CYCLES   = DEF_FLUSH_CYCLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES,
    parameter int LEN_W          = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] burst_len,
    output logic             chain_reset,
    output logic             chain_en,
    input  logic             chain_ce,
    input  logic [DW-1:0]    chain_data,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic [OVR_W-1:0] overrun_cnt
);

    localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
    localparam int ST_W = $clog2(SETTLE_SAMPLES + 1);
    localparam logic [FL_W-1:0] FLUSH_LAST  = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_SAMPLES - 1);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             done_d;
    logic [FL_W-1:0]  flush_cnt;
    logic [ST_W-1:0]  settle_cnt;
    logic [LEN_W-1:0] fwd_cnt;
    logic [LEN_W-1:0] len_q;
    logic             start_ok;
    logic             stop_ok;
    logic             run_ce;
    logic             burst_end;

    // Stop beats start; start is only honoured from IDLE.
    assign stop_ok   = stop && (state_q != ST_IDLE);
    assign start_ok  = start && !stop && (state_q == ST_IDLE);
    assign run_ce    = (state_q == ST_RUN) && chain_ce && !stop;
    assign burst_end = run_ce && (len_q != '0) && ((fwd_cnt + LEN_W'(1)) == len_q);

    // Next-state decode and burst-complete detection.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a value unassigned (no latch).
        state_d = state_q;
        done_d  = 1'b0;
        if (stop_ok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start_ok) state_d = ST_FLUSH;
                ST_FLUSH:  if (flush_cnt == FLUSH_LAST) state_d = ST_SETTLE;
                ST_SETTLE: if (chain_ce && (settle_cnt == SETTLE_LAST)) state_d = ST_RUN;
                ST_RUN: begin
                    if (burst_end) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            chain_reset <= 1'b1;
            chain_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            chain_reset <= (state_d == ST_IDLE) || (state_d == ST_FLUSH);
            chain_en    <= (state_d == ST_SETTLE) || (state_d == ST_RUN);
            busy        <= (state_d != ST_IDLE);
            done        <= done_d;
        end
    end

    // Flush, settle and forwarded-sample counters; burst length latched on start.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            flush_cnt  <= '0;
            settle_cnt <= '0;
            fwd_cnt    <= '0;
            len_q      <= '0;
        end else if (start_ok) begin
            flush_cnt  <= '0;
            settle_cnt <= '0;
            fwd_cnt    <= '0;
            len_q      <= burst_len;
        end else begin
            if (state_q == ST_FLUSH) flush_cnt <= flush_cnt + FL_W'(1);
            if ((state_q == ST_SETTLE) && chain_ce) settle_cnt <= settle_cnt + ST_W'(1);
            if (run_ce) fwd_cnt <= fwd_cnt + LEN_W'(1);
        end
    end

    decim_hold_reg #(
        .DW (DW)
    ) u_hold (
        .clk         (clk),
        .arst_n      (arst_n),
        .flush       (stop_ok),
        .ovr_clear   (start_ok),
        .in_valid    (run_ce),
        .in_data     (chain_data),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .overrun_cnt (overrun_cnt)
    );

endmodule
